// File: rtl/mult_div_pipe.sv
// RV32M multiply/divide unit: pipelined multiplier plus iterative restoring divider
// sharing one output register; results retire in completion order with their ROB tag.
module mult_div_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ROB_DEPTH  = 16,
  parameter int unsigned MUL_STAGES = 3,
  localparam int unsigned TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned LAST  = MUL_STAGES - 1;
  localparam int unsigned CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Multiplier pipeline state
  logic [MUL_STAGES-1:0] mul_valid_q;
  logic [2*XLEN-1:0]     mul_prod_q [MUL_STAGES];
  logic [1:0]            mul_f3_q   [MUL_STAGES];
  logic [TAG_W-1:0]      mul_tag_q  [MUL_STAGES];

  // Divider state
  logic [1:0]       div_state_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [XLEN-1:0]  div_rem_q;
  logic [XLEN-1:0]  div_quo_q;
  logic [XLEN-1:0]  div_dvsr_q;
  logic [XLEN-1:0]  div_rs1_q;
  logic [XLEN-1:0]  div_res_q;
  logic [TAG_W-1:0] div_tag_q;
  logic             div_qneg_q;
  logic             div_rneg_q;
  logic             div_is_rem_q;
  logic             div_zero_q;
  logic             div_ovf_q;

  // Output register
  logic             out_valid_q;
  logic [XLEN-1:0]  out_result_q;
  logic [TAG_W-1:0] out_tag_q;

  logic             div_done;
  logic             out_free;
  logic             div_to_out;
  logic             mul_to_out;
  logic             mul_advance;
  logic             mul_load0;
  logic             accept;
  logic             mul_accept;
  logic             div_accept;
  logic             rs1_sgn;
  logic             rs2_sgn;
  logic [2*XLEN-1:0] mul_a;
  logic [2*XLEN-1:0] mul_b;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]  mul_sel;
  logic             div_sgn;
  logic             div_a_neg;
  logic             div_b_neg;
  logic [XLEN:0]    div_shift;
  logic [XLEN:0]    div_trial;
  logic [XLEN-1:0]  div_q_fix;
  logic [XLEN-1:0]  div_r_fix;
  logic [XLEN-1:0]  div_fix_res;

  // Divider result beats a waiting multiplier; the multiplier then stalls as a whole.
  assign div_done    = (div_state_q == DIV_DONE);
  assign out_free    = !out_valid_q || out_ready;
  assign div_to_out  = div_done && out_free;
  assign mul_to_out  = mul_valid_q[LAST] && out_free && !div_done;
  assign mul_advance = !mul_valid_q[LAST] || mul_to_out;
  assign mul_load0   = mul_advance || !mul_valid_q[0];

  always_comb begin
    in_ready = 1'b0;
    if (!(rst || flush)) begin
      if (in_funct3[2]) begin
        in_ready = (div_state_q == DIV_IDLE);
      end else begin
        in_ready = mul_load0;
      end
    end
  end

  assign accept     = in_valid && in_ready;
  assign mul_accept = accept && !in_funct3[2];
  assign div_accept = accept && in_funct3[2];

  // Widen each operand to 2*XLEN; the low 2*XLEN product bits then match the signed product.
  assign rs1_sgn  = (in_funct3[1:0] != 2'b11);
  assign rs2_sgn  = !in_funct3[1];
  assign mul_a    = {{XLEN{rs1_sgn && in_rs1[XLEN-1]}}, in_rs1};
  assign mul_b    = {{XLEN{rs2_sgn && in_rs2[XLEN-1]}}, in_rs2};
  assign mul_prod = mul_a * mul_b;
  assign mul_sel  = (mul_f3_q[LAST] == 2'b00) ? mul_prod_q[LAST][XLEN-1:0]
                                              : mul_prod_q[LAST][2*XLEN-1:XLEN];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mul_valid_q <= '0;
    end else if (mul_advance) begin
      for (int i = int'(LAST); i > 0; i--) begin
        mul_valid_q[i] <= mul_valid_q[i-1];
      end
      mul_valid_q[0] <= mul_accept;
    end else if (!mul_valid_q[0]) begin
      mul_valid_q[0] <= mul_accept;
    end
  end

  always_ff @(posedge clk) begin
    if (mul_load0) begin
      mul_prod_q[0] <= mul_prod;
      mul_f3_q[0]   <= in_funct3[1:0];
      mul_tag_q[0]  <= in_tag;
    end
    if (mul_advance) begin
      for (int i = int'(LAST); i > 0; i--) begin
        mul_prod_q[i] <= mul_prod_q[i-1];
        mul_f3_q[i]   <= mul_f3_q[i-1];
        mul_tag_q[i]  <= mul_tag_q[i-1];
      end
    end
  end

  assign div_sgn   = !in_funct3[0];
  assign div_a_neg = div_sgn && in_rs1[XLEN-1];
  assign div_b_neg = div_sgn && in_rs2[XLEN-1];
  assign div_shift = {div_rem_q, div_quo_q[XLEN-1]};
  assign div_trial = div_shift - {1'b0, div_dvsr_q};
  assign div_q_fix = div_qneg_q ? -div_quo_q : div_quo_q;
  assign div_r_fix = div_rneg_q ? -div_rem_q : div_rem_q;

  // Special cases are picked in FIX so they cost the same latency as a normal divide.
  always_comb begin
    div_fix_res = div_is_rem_q ? div_r_fix : div_q_fix;
    if (div_zero_q) begin
      div_fix_res = div_is_rem_q ? div_rs1_q : '1;
    end else if (div_ovf_q) begin
      div_fix_res = div_is_rem_q ? '0 : div_rs1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (div_accept) begin
            div_state_q <= DIV_CALC;
            div_cnt_q   <= '0;
          end
        end
        DIV_CALC: begin
          div_cnt_q <= div_cnt_q + 1'b1;
          if (div_cnt_q == CNT_W'(XLEN - 1)) begin
            div_state_q <= DIV_FIX;
          end
        end
        DIV_FIX:  div_state_q <= DIV_DONE;
        DIV_DONE: begin
          if (div_to_out) begin
            div_state_q <= DIV_IDLE;
          end
        end
        default:  div_state_q <= DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (div_accept) begin
      div_rem_q    <= '0;
      div_quo_q    <= div_a_neg ? -in_rs1 : in_rs1;
      div_dvsr_q   <= div_b_neg ? -in_rs2 : in_rs2;
      div_rs1_q    <= in_rs1;
      div_tag_q    <= in_tag;
      div_qneg_q   <= div_a_neg ^ div_b_neg;
      div_rneg_q   <= div_a_neg;
      div_is_rem_q <= in_funct3[1];
      div_zero_q   <= (in_rs2 == '0);
      div_ovf_q    <= div_sgn && (in_rs1 == MOST_NEG) && (in_rs2 == '1);
    end else if (div_state_q == DIV_CALC) begin
      if (!div_trial[XLEN]) begin
        div_rem_q <= div_trial[XLEN-1:0];
        div_quo_q <= {div_quo_q[XLEN-2:0], 1'b1};
      end else begin
        div_rem_q <= div_shift[XLEN-1:0];
        div_quo_q <= {div_quo_q[XLEN-2:0], 1'b0};
      end
    end
    if (div_state_q == DIV_FIX) begin
      div_res_q <= div_fix_res;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (div_to_out) begin
      out_valid_q  <= 1'b1;
      out_result_q <= div_res_q;
      out_tag_q    <= div_tag_q;
    end else if (mul_to_out) begin
      out_valid_q  <= 1'b1;
      out_result_q <= mul_sel;
      out_tag_q    <= mul_tag_q[LAST];
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign busy       = (|mul_valid_q) || (div_state_q != DIV_IDLE) || out_valid_q;

endmodule
